// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// instruction field constants, FSM state and operation type encodings.
package muldiv_pkg;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  typedef enum logic [1:0] {
    MULT,
    MULTU,
    DIV,
    DIVU
  } op_t;

endpackage

// File: rtl/exec_muldiv_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
// master = pipeline side (drives instruction/operands), slave = muldiv unit.
interface exec_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic [31:0]      i_instr_exec;
  logic [WIDTH-1:0] i_op1_exec;
  logic [WIDTH-1:0] i_op2_exec;
  logic             o_stall;
  logic             o_busy;
  logic             o_hilo_valid;
  logic [WIDTH-1:0] o_hilo_data;

  modport master (
    output i_valid, i_instr_exec, i_op1_exec, i_op2_exec,
    input  o_stall, o_busy, o_hilo_valid, o_hilo_data
  );

  modport slave (
    input  i_valid, i_instr_exec, i_op1_exec, i_op2_exec,
    output o_stall, o_busy, o_hilo_valid, o_hilo_data
  );
endinterface

// File: rtl/muldiv_iter.sv
// Magnitude datapath of the multiply/divide unit. Operands are captured as
// magnitudes on i_start; every i_step performs one shift-add (multiply) or
// one restoring-division step. o_hi/o_lo present the sign-corrected result
// combinationally so the owner can latch it during its fix-up cycle.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_a_rst,
  input  logic             i_start,
  input  logic             i_step,
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic               w_signed;
  logic               w_is_div;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;

  logic [WIDTH-1:0]   r_a;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_b;      // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0]   r_acc;    // product high / partial remainder
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_q;  // negate product (mult) or quotient (div)
  logic               r_neg_r;  // negate remainder (signed div, negative dividend)
  logic               r_div0;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_fits;
  logic               w_unused_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  assign w_signed = (i_op == MULT) || (i_op == DIV);
  assign w_is_div = (i_op == DIV) || (i_op == DIVU);
  assign w_neg1   = w_signed & i_op1[WIDTH-1];
  assign w_neg2   = w_signed & i_op2[WIDTH-1];
  assign w_mag1   = w_neg1 ? -i_op1 : i_op1;
  assign w_mag2   = w_neg2 ? -i_op2 : i_op2;

  // Multiply step: conditionally add multiplicand, then shift {acc,b} right.
  assign w_addend = r_b[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

  // Divide step: shift {acc,b} left, trial-subtract divisor; sign bit = borrow.
  assign w_shift       = {r_acc, r_b[WIDTH-1]};
  assign w_diff        = {1'b0, w_shift} - {2'b00, r_a};
  assign w_fits        = ~w_diff[WIDTH+1];
  assign w_unused_diff = w_diff[WIDTH];

  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Capture operand magnitudes on start, then iterate one bit per step.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else if (i_start) begin
      r_a      <= w_mag2;
      r_b      <= w_mag1;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_is_div <= w_is_div;
      r_neg_q  <= w_neg1 ^ w_neg2;
      r_neg_r  <= w_is_div & w_neg1;
      r_div0   <= w_is_div & (i_op2 == '0);
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_is_div) begin
        if (w_fits) begin
          r_acc <= w_diff[WIDTH-1:0];
          r_b   <= {r_b[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_shift[WIDTH-1:0];
          r_b   <= {r_b[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
      end
    end
  end

  assign w_prod     = {r_acc, r_b};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Sign correction. A zero divisor leaves an all-ones quotient and the
  // dividend as remainder; the quotient must not be negated in that case.
  always_comb begin
    if (r_is_div) begin
      o_lo = r_div0 ? '1 : (r_neg_q ? -r_b : r_b);
      o_hi = r_neg_r ? -r_acc : r_acc;
    end else begin
      o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      o_lo = w_prod_fix[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Execute-stage multiply/divide unit with architectural HI/LO. Decodes the
// execute instruction, runs MULT/MULTU/DIV/DIVU in the background, serves
// MFHI/MFLO/MTHI/MTLO and stalls the pipeline on any HI/LO access while busy.
module exec_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic          i_clk,
  input logic          i_a_rst,
  input logic          i_s_rst,
  exec_muldiv_if.slave bus
);

  logic [5:0]       w_funct;
  logic             w_special;
  logic             w_is_md;
  logic             w_is_mf;
  logic             w_is_mt;
  logic             w_sel_hi;
  op_t              w_op;
  logic             w_unused_instr;

  state_t           r_state;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_valid;
  logic             w_start;
  logic             w_mt_we;
  logic             w_last;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  assign w_funct        = bus.i_instr_exec[5:0];
  assign w_special      = (bus.i_instr_exec[31:26] == OPC_SPECIAL);
  assign w_unused_instr = ^bus.i_instr_exec[25:6];

  // Classify the execute instruction; anything unrecognised is ignored.
  always_comb begin
    w_is_md  = 1'b0;
    w_is_mf  = 1'b0;
    w_is_mt  = 1'b0;
    w_sel_hi = 1'b0;
    w_op     = MULT;
    if (w_special) begin
      case (w_funct)
        FUNCT_MFHI:  begin w_is_mf = 1'b1; w_sel_hi = 1'b1; end
        FUNCT_MTHI:  begin w_is_mt = 1'b1; w_sel_hi = 1'b1; end
        FUNCT_MFLO:  w_is_mf = 1'b1;
        FUNCT_MTLO:  w_is_mt = 1'b1;
        FUNCT_MULT:  begin w_is_md = 1'b1; w_op = MULT;  end
        FUNCT_MULTU: begin w_is_md = 1'b1; w_op = MULTU; end
        FUNCT_DIV:   begin w_is_md = 1'b1; w_op = DIV;   end
        FUNCT_DIVU:  begin w_is_md = 1'b1; w_op = DIVU;  end
        default:     ;
      endcase
    end
  end

  // Combinational outputs are forced quiet while the async reset is held.
  assign w_valid = bus.i_valid & ~i_a_rst;
  assign w_start = w_valid & w_is_md & ~r_busy & ~i_s_rst;
  assign w_mt_we = w_valid & w_is_mt & ~r_busy & ~i_s_rst;

  assign bus.o_stall      = w_valid & (w_is_md | w_is_mf | w_is_mt) & r_busy;
  assign bus.o_busy       = r_busy;
  assign bus.o_hilo_valid = w_valid & w_is_mf & ~r_busy;
  assign bus.o_hilo_data  = bus.o_hilo_valid ? (w_sel_hi ? r_hi : r_lo) : '0;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .i_clk   (i_clk),
    .i_a_rst (i_a_rst),
    .i_start (w_start),
    .i_step  (r_state == CALC),
    .i_op    (w_op),
    .i_op1   (bus.i_op1_exec),
    .i_op2   (bus.i_op2_exec),
    .o_last  (w_last),
    .o_hi    (w_res_hi),
    .o_lo    (w_res_lo)
  );

  // Control FSM plus HI/LO: flush aborts without touching HI/LO.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_s_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
          end else if (w_mt_we) begin
            if (w_sel_hi) r_hi <= bus.i_op1_exec;
            else          r_lo <= bus.i_op1_exec;
          end
        end
        CALC: begin
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_muldiv.sv
// Bench for exec_muldiv: directed cases with literal results, then random
// traffic checked every cycle against a cycle-count / arithmetic model.
module tb_exec_muldiv;

  logic clk;
  logic a_rst;
  logic s_rst;
  int   errors = 0;
  int   checks = 0;

  exec_muldiv_if #(.WIDTH(32)) bus ();

  exec_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
    .i_clk   (clk),
    .i_a_rst (a_rst),
    .i_s_rst (s_rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [63:0] m_pend = 0;
  int          m_rem = 0;   // cycles until the pending result lands

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = ignored, 1 = mul/div, 2 = move-from, 3 = move-to
  function automatic int cls_of(input logic [31:0] ins);
    if (ins[31:26] != 6'd0) return 0;
    case (ins[5:0])
      6'h18, 6'h19, 6'h1A, 6'h1B: return 1;
      6'h10, 6'h12:               return 2;
      6'h11, 6'h13:               return 3;
      default:                    return 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] r;
    longint      sa, sb, q, m, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      6'h18: begin p = sa * sb; r = p; end
      6'h19: r = {32'd0, a} * {32'd0, b};
      6'h1A: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
      end
      6'h1B: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Per-cycle compare, then advance the model by the coming clock edge.
  initial begin
    logic        e_busy, e_stall, e_hv;
    logic [31:0] e_data;
    int          c;
    forever begin
      @(negedge clk);
      c = cls_of(bus.i_instr_exec);
      if (a_rst) begin
        m_hi = 0; m_lo = 0; m_rem = 0;
        e_busy = 0; e_stall = 0; e_hv = 0; e_data = 0;
      end else begin
        e_busy  = (m_rem > 0);
        e_stall = bus.i_valid && (c != 0) && e_busy;
        e_hv    = bus.i_valid && (c == 2) && !e_busy;
        e_data  = e_hv ? ((bus.i_instr_exec[1] == 1'b0) ? m_hi : m_lo) : 32'd0;
      end
      chk("busy", bus.o_busy, e_busy);
      chk("stall", bus.o_stall, e_stall);
      chk("hilo_valid", bus.o_hilo_valid, e_hv);
      chk("hilo_data", bus.o_hilo_data, e_data);
      if (!a_rst) begin
        if (s_rst) m_rem = 0;
        else if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) {m_hi, m_lo} = m_pend;
        end else if (bus.i_valid && c == 1) begin
          m_pend = ref_md(bus.i_instr_exec[5:0], bus.i_op1_exec, bus.i_op2_exec);
          m_rem  = 33;
        end else if (bus.i_valid && c == 3) begin
          if (bus.i_instr_exec[1] == 1'b0) m_hi = bus.i_op1_exec;
          else                             m_lo = bus.i_op1_exec;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b);
    bus.i_valid      = v;
    bus.i_instr_exec = ins;
    bus.i_op1_exec   = a;
    bus.i_op2_exec   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.o_busy && k < 100) begin
      issue(1'b0, 32'd0, 32'd0, 32'd0);
      k++;
    end
    if (bus.o_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy after %0d cycles required idle", k);
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    wait_idle();
    issue(1'b1, mk(f), a, b);
  endtask

  // Present MFHI/MFLO until accepted; count the stalled cycles.
  task automatic wait_mf(input logic [5:0] f, input logic [31:0] exp, input string name,
                         output int stalls);
    bit got;
    got    = 0;
    stalls = 0;
    bus.i_valid      = 1'b1;
    bus.i_instr_exec = mk(f);
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (bus.o_hilo_valid) begin
        got = 1;
        chk(name, bus.o_hilo_data, exp);
      end else if (bus.o_stall) stalls++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: got no hilo_valid in 100 cycles required acceptance", name);
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [5:0]  f;
    case ($urandom_range(0, 11))
      0:       f = 6'h10;
      1:       f = 6'h11;
      2:       f = 6'h12;
      3:       f = 6'h13;
      4:       f = 6'h18;
      5:       f = 6'h19;
      6:       f = 6'h1A;
      7:       f = 6'h1B;
      8:       f = 6'h20;
      9:       f = 6'h2A;
      default: f = 6'($urandom_range(0, 63));
    endcase
    ins = $urandom;
    ins[5:0] = f;
    if ($urandom_range(0, 9) != 0) ins[31:26] = 6'd0;
    return ins;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int st;
    a_rst = 1'b1;
    s_rst = 1'b0;
    bus.i_valid      = 1'b0;
    bus.i_instr_exec = 32'd0;
    bus.i_op1_exec   = 32'd0;
    bus.i_op2_exec   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;

    // MULTU max*max with MFHI the very next cycle
    run_op(6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_mf(6'h10, 32'hFFFFFFFE, "multu_hi", st);
    chk("multu_stall_cycles", st, 33);
    wait_mf(6'h12, 32'h00000001, "multu_lo", st);

    run_op(6'h18, -32'sd3, 32'd7);
    wait_mf(6'h10, 32'hFFFFFFFF, "mult_hi", st);
    wait_mf(6'h12, 32'hFFFFFFEB, "mult_lo", st);

    run_op(6'h1A, -32'sd7, 32'd2);
    wait_mf(6'h12, 32'hFFFFFFFD, "div_lo", st);
    wait_mf(6'h10, 32'hFFFFFFFF, "div_hi", st);

    run_op(6'h1B, 32'd100, 32'd0);
    wait_mf(6'h12, 32'hFFFFFFFF, "divu0_lo", st);
    wait_mf(6'h10, 32'd100, "divu0_hi", st);

    run_op(6'h1A, 32'h80000000, 32'hFFFFFFFF);
    wait_mf(6'h12, 32'h80000000, "divovf_lo", st);
    wait_mf(6'h10, 32'h00000000, "divovf_hi", st);

    // MTLO then MFLO next cycle while idle
    wait_idle();
    issue(1'b1, mk(6'h13), 32'h1234, 32'd0);
    wait_mf(6'h12, 32'h1234, "mtlo_mflo", st);
    chk("mtlo_nostall", st, 0);

    // Flush ten cycles into a MULT
    issue(1'b1, mk(6'h11), 32'hAAAA, 32'd0);
    issue(1'b1, mk(6'h13), 32'h5555, 32'd0);
    issue(1'b1, mk(6'h18), 32'd5, 32'd6);
    repeat (9) issue(1'b0, 32'd0, 32'd0, 32'd0);
    s_rst = 1'b1;
    issue(1'b0, 32'd0, 32'd0, 32'd0);
    s_rst = 1'b0;
    @(negedge clk);
    chk("srst_busy_low", bus.o_busy, 0);
    @(posedge clk);
    #1;
    wait_mf(6'h10, 32'hAAAA, "srst_hi_kept", st);
    wait_mf(6'h12, 32'h5555, "srst_lo_kept", st);

    // Non-muldiv traffic while busy must not stall
    run_op(6'h19, 32'd3, 32'd4);
    for (int k = 0; k < 5; k++) begin
      bus.i_valid      = 1'b1;
      bus.i_instr_exec = mk(6'h20);
      @(negedge clk);
      chk("add_nostall", bus.o_stall, 0);
      @(posedge clk);
      #1;
    end
    wait_mf(6'h12, 32'd12, "bg_lo", st);
    wait_mf(6'h10, 32'd0, "bg_hi", st);

    // Async reset twenty cycles into a DIV
    issue(1'b1, mk(6'h11), 32'h77, 32'd0);
    issue(1'b1, mk(6'h1A), 32'd1000, 32'd7);
    repeat (19) issue(1'b0, 32'd0, 32'd0, 32'd0);
    bus.i_valid      = 1'b1;
    bus.i_instr_exec = mk(6'h10);
    #1;
    chk("pre_arst_stall", bus.o_stall, 1);
    a_rst = 1'b1;
    #1;
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_stall", bus.o_stall, 0);
    chk("arst_hilo_valid", bus.o_hilo_valid, 0);
    chk("arst_hilo_data", bus.o_hilo_data, 0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    wait_mf(6'h10, 32'd0, "arst_hi_cleared", st);
    chk("arst_mf_nostall", st, 0);

    // Random traffic against the model
    for (int n = 0; n < 2500; n++) begin
      s_rst = ($urandom_range(0, 49) == 0);
      issue(($urandom_range(0, 9) < 8), rand_instr(), rand_opnd(), rand_opnd());
    end
    s_rst = 1'b0;
    repeat (40) issue(1'b0, 32'd0, 32'd0, 32'd0);
    wait_mf(6'h10, m_hi, "final_hi", st);
    wait_mf(6'h12, m_lo, "final_lo", st);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by %0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
